// File: rtl/popcount_stream_acc.sv
// Streaming popcount accumulator: sums the set (or clear) bits of each accepted
// beat over a frame and holds the saturated frame total until the consumer takes it.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  ST_ACC  | accepting beats, accumulating the running count/beat total
//  ST_HOLD | frame closed; result presented on out_* until out_ready
module popcount_stream_acc #(
    parameter int WIDTH      = 32,
    parameter int ACC_WIDTH  = 16,
    parameter int BEAT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_last,
    input  logic                  in_zeros,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_count,
    output logic [BEAT_WIDTH-1:0] out_beats,
    output logic                  out_sat
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [BEAT_WIDTH-1:0] beats_q, beats_d;
    logic                  sat_q, sat_d;

    logic [WIDTH-1:0]      word;
    logic [CW-1:0]         bit_cnt;
    logic [ACC_WIDTH:0]    acc_sum;
    logic [ACC_WIDTH-1:0]  acc_clamped;
    logic                  acc_ovf;
    logic [BEAT_WIDTH-1:0] beats_inc;
    logic                  beats_full;

    assign word = in_zeros ? ~in_data : in_data;

    always_comb begin
        bit_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bit_cnt = bit_cnt + CW'(word[i]);
        end
    end

    // One extra bit of headroom so an overflowing sum is detected, never wrapped.
    assign acc_sum     = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - CW){1'b0}}, bit_cnt};
    assign acc_ovf     = acc_sum[ACC_WIDTH];
    assign acc_clamped = acc_ovf ? {ACC_WIDTH{1'b1}} : acc_sum[ACC_WIDTH-1:0];

    assign beats_full = &beats_q;
    assign beats_inc  = beats_full ? beats_q : beats_q + BEAT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            beats_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            beats_q <= beats_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        beats_d = beats_q;
        sat_d   = sat_q;
        case (state_q)
            ST_ACC: begin
                if (in_valid) begin
                    acc_d   = acc_clamped;
                    beats_d = beats_inc;
                    sat_d   = sat_q | acc_ovf | beats_full;
                    if (in_last) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                    acc_d   = '0;
                    beats_d = '0;
                    sat_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // Handshake outputs come straight from the state register.
    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign out_count = acc_q;
    assign out_beats = beats_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_popcount_stream_acc.sv
// Self-checking bench for popcount_stream_acc: directed vector table, hand-written
// handshake/reset sequences, and a random stream against a frame-level model.
module tb_popcount_stream_acc;

    localparam int W  = 32;
    localparam int AW = 8;
    localparam int BW = 4;
    localparam int ACC_MAX  = (1 << AW) - 1;
    localparam int BEAT_MAX = (1 << BW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          in_zeros;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_count;
    logic [BW-1:0] out_beats;
    logic          out_sat;

    popcount_stream_acc #(.WIDTH(W), .ACC_WIDTH(AW), .BEAT_WIDTH(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_zeros  (in_zeros),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_beats (out_beats),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic        zeros;
        logic        last;
        logic        exp_valid;
        int          exp_count;
        int          exp_beats;
        logic        exp_sat;
    } vec_t;

    typedef struct {
        int   count;
        int   beats;
        logic sat;
    } frame_t;

    vec_t   vecs[$];
    frame_t exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [31:0] d, input logic z, input logic l,
                       input logic v, input int c, input int b, input logic s);
        vec_t r;
        r.data = d; r.zeros = z; r.last = l;
        r.exp_valid = v; r.exp_count = c; r.exp_beats = b; r.exp_sat = s;
        vecs.push_back(r);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic z, input logic l);
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
        in_valid = 1'b1; in_data = d; in_zeros = z; in_last = l;
        step();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic check_result(input string tag, input int c, input int b, input logic s);
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_count"}, int'(out_count), c);
        check({tag, "_beats"}, int'(out_beats), b);
        check({tag, "_sat"},   int'(out_sat),   int'(s));
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_xfer_ready", int'(in_ready), 1);
        check("post_xfer_count", int'(out_count), 0);
    endtask

    // Frame-level expectation: clamping a sum of non-negative terms stepwise
    // equals clamping the plain total once.
    function automatic frame_t model_frame(input int raw_total, input int raw_beats);
        frame_t f;
        f.count = (raw_total > ACC_MAX) ? ACC_MAX : raw_total;
        f.beats = (raw_beats > BEAT_MAX) ? BEAT_MAX : raw_beats;
        f.sat   = (raw_total > ACC_MAX) || (raw_beats > BEAT_MAX);
        return f;
    endfunction

    initial begin
        int cur_total, cur_beats, frames_done, n;
        logic [31:0] w;
        frame_t f;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        in_zeros = 1'b0; out_ready = 1'b0;
        step();
        step();
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_count",     int'(out_count), 0);
        check("rst_beats",     int'(out_beats), 0);
        check("rst_sat",       int'(out_sat),   0);
        rst = 1'b0;
        step();

        // ---------------- directed vector table ----------------
        add(32'hFFFF_FFFF, 0, 0, 0, 32, 1, 0);
        add(32'h0000_000F, 0, 1, 1, 36, 2, 0);
        add(32'h0000_00FF, 1, 0, 0, 24, 1, 0);
        add(32'h0000_00FF, 0, 1, 1, 32, 2, 0);
        add(32'h0000_0000, 0, 1, 1, 0, 1, 0);
        add(32'hFFFF_FFFF, 1, 1, 1, 0, 1, 0);
        add(32'h0000_0000, 1, 1, 1, 32, 1, 0);
        for (int i = 1; i <= 9; i++)
            add(32'hFFFF_FFFF, 0, (i == 9), (i == 9),
                (32 * i > ACC_MAX) ? ACC_MAX : 32 * i, i, (32 * i > ACC_MAX));
        for (int i = 1; i <= 7; i++)
            add(32'hFFFF_FFFF, 0, 0, 0, 32 * i, i, 0);
        add(32'h7FFF_FFFF, 0, 1, 1, 255, 8, 0);
        for (int i = 1; i <= 16; i++)
            add(32'h0000_0000, 0, (i == 16), (i == 16), 0,
                (i > BEAT_MAX) ? BEAT_MAX : i, (i > BEAT_MAX));

        for (int i = 0; i < vecs.size(); i++) begin
            send_beat(vecs[i].data, vecs[i].zeros, vecs[i].last);
            check($sformatf("vec%0d_valid", i), int'(out_valid), int'(vecs[i].exp_valid));
            check($sformatf("vec%0d_count", i), int'(out_count), vecs[i].exp_count);
            check($sformatf("vec%0d_beats", i), int'(out_beats), vecs[i].exp_beats);
            check($sformatf("vec%0d_sat", i),   int'(out_sat),   int'(vecs[i].exp_sat));
            if (vecs[i].last) take_result();
        end

        // ---------------- back-pressure ----------------
        send_beat(32'h0000_0001, 0, 1);
        check_result("bp_first", 1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_last = 1'b1;
            step();
            check("bp_in_ready", int'(in_ready), 0);
            check_result("bp_stall", 1, 1, 0);
        end
        in_valid = 1'b0; in_last = 1'b0;
        take_result();
        check("bp_out_valid_after", int'(out_valid), 0);
        send_beat(32'h0000_0003, 0, 1);
        check_result("bp_next", 2, 1, 0);
        take_result();

        // ---------------- reset mid-frame / with beat / in HOLD ----------------
        for (int i = 0; i < 3; i++) send_beat(32'h0000_0001, 0, 0);
        check("mid_partial", int'(out_count), 3);
        rst = 1'b1;
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_last = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check("mid_rst_count", int'(out_count), 0);
        check("mid_rst_beats", int'(out_beats), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        send_beat(32'h0000_0003, 0, 1);
        check_result("after_rst", 2, 1, 0);
        rst = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; out_ready = 1'b0;
        check("hold_rst_valid", int'(out_valid), 0);
        check("hold_rst_ready", int'(in_ready),  1);
        check("hold_rst_count", int'(out_count), 0);

        // ---------------- random stream vs frame model ----------------
        cur_total = 0; cur_beats = 0; frames_done = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_data   = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & $urandom & $urandom);
            in_zeros  = ($urandom_range(0, 5) == 0);
            in_last   = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_spurious_frame", 1, 0);
                end else begin
                    f = exp_q.pop_front();
                    check("rnd_count", int'(out_count), f.count);
                    check("rnd_beats", int'(out_beats), f.beats);
                    check("rnd_sat",   int'(out_sat),   int'(f.sat));
                    frames_done++;
                end
            end
            if (in_valid && in_ready) begin
                w = in_zeros ? ~in_data : in_data;
                cur_total += $countones(w);
                cur_beats++;
                if (in_last) begin
                    exp_q.push_back(model_frame(cur_total, cur_beats));
                    cur_total = 0; cur_beats = 0;
                end
            end
            step();
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            if (out_valid) begin
                f = exp_q.pop_front();
                check("drain_count", int'(out_count), f.count);
                check("drain_beats", int'(out_beats), f.beats);
                check("drain_sat",   int'(out_sat),   int'(f.sat));
                frames_done++;
            end
            step();
            n++;
        end
        check("rnd_pending_frames", exp_q.size(), 0);
        check("rnd_enough_frames", int'(frames_done >= 50), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/popcount_stream_acc.md
POPCOUNT_STREAM_ACC -- requirements
Module: popcount_stream_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, input word width; power of two, >= 2.
REQ-002 SHALL have parameter ACC_WIDTH, default 16, accumulator/result width; >= $clog2(WIDTH)+1.
REQ-003 SHALL have parameter BEAT_WIDTH, default 8, beat-counter width; >= 1.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  input beat present.
REQ-007 SHALL have port in_data  input  WIDTH  word to count.
REQ-008 SHALL have port in_last  input  1  beat closes the current frame.
REQ-009 SHALL have port in_zeros  input  1  1 = count zero bits, 0 = count one bits; sampled per beat.
REQ-010 SHALL have port in_ready  output  1  block accepts a beat.
REQ-011 SHALL have port out_valid  output  1  frame result present.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port out_count  output  ACC_WIDTH  frame total bit count.
REQ-014 SHALL have port out_beats  output  BEAT_WIDTH  beats in frame, saturating.
REQ-015 SHALL have port out_sat  output  1  out_count or out_beats clamped during frame.

Function
REQ-016 Beat accepted iff in_valid && in_ready at a rising edge; frame result transferred iff out_valid && out_ready.
REQ-017 FSM states: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1); no other states.
REQ-018 Per-beat count = number of 1 bits of in_data (in_zeros=0) or of ~in_data (in_zeros=1), range 0..WIDTH; in_zeros may differ per beat within a frame.
REQ-019 In ACC, on accepted beat: acc <= min(acc + count, 2^ACC_WIDTH-1); beats <= min(beats+1, 2^BEAT_WIDTH-1); sat flag set sticky if either clamped.
REQ-020 In ACC, accepted beat with in_last=1: state -> HOLD; out_count/out_beats/out_sat take the values including that beat; out_valid high from the following cycle (latency 1 cycle from last-beat edge).
REQ-021 Single-beat frame (in_last on first beat) SHALL behave per REQ-020 with out_beats=1.
REQ-022 Accepted beat with in_data having no counted bits SHALL still increment beats.
REQ-023 In HOLD, out_count/out_beats/out_sat SHALL be stable until transfer; in_data/in_valid ignored.
REQ-024 In HOLD, on transfer: state -> ACC, acc/beats/sat cleared to 0; in_ready high next cycle (1 bubble cycle between frames).
REQ-025 out_ready low in HOLD SHALL stall indefinitely without result change.
REQ-026 In ACC, out_count/out_beats/out_sat SHALL reflect the running partial values (don't-care to consumer since out_valid=0).
REQ-027 No combinational path from in_valid or out_ready to in_ready or out_valid; both decoded from state register only.
REQ-028 Accumulator addition SHALL be computed at ACC_WIDTH+1 bits before clamp; no wrap-around permitted.

Reset
REQ-029 On rst=1 at a rising edge: state=ACC, acc=0, beats=0, sat=0; out_valid=0, in_ready=1, out_count=0, out_beats=0, out_sat=0 in the following cycle.
REQ-030 rst SHALL override any simultaneous beat acceptance or result transfer; a partial frame or held result is discarded.

Verification
REQ-031 WIDTH=32: beats 0xFFFFFFFF, 0x0000000F(last), in_zeros=0, out_ready=1 -> out_valid one cycle after last edge, out_count=36, out_beats=2, out_sat=0.
REQ-032 Mixed mode: 0x000000FF (zeros=1), 0x000000FF (zeros=0, last) -> out_count=32, out_beats=2.
REQ-033 ACC_WIDTH=8, WIDTH=32: nine beats of 0xFFFFFFFF, last on ninth -> out_count=255, out_beats=9, out_sat=1.
REQ-034 Back-pressure: hold out_ready=0 for 10 cycles after result -> in_ready=0, outputs constant; raise out_ready -> transfer, in_ready=1 next cycle, next frame's count starts from 0.
REQ-035 Reset mid-frame after 3 beats of 0x1, then frame 0x3(last) -> out_count=2, out_beats=1; reset during HOLD -> out_valid=0 next cycle.
REQ-036 Random streams with random in_valid/out_ready gaps vs scoreboard model -> every frame result matches; no beat lost or double-counted.
